bcd_time_packer: RTL
====================

# bcd_time_packer

Sequential BCD-to-binary time packer: the inverse of the per-field binary-to-BCD stage that feeds the VGA display. It accepts four two-digit BCD fields (hours, minutes, seconds, ms), validates them, and converts them one field per cycle. It emits the packed 27-bit time word used by the clock, timer and stopwatch blocks and the 4-to-1 time mux. The intended use is the time-set path, where user-entered digits load a counter preset.

## Interface
Parameters:
- HR_MAX, 23, largest legal hours value (11 for the 12-hour preset path)
- MIN_MAX, 59, largest legal minutes value
- SEC_MAX, 59, largest legal seconds value
- MS_MAX, 63, largest legal ms value; must be ≤ 63 (6-bit field)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  conversion request, sampled on rising edge of clk
- hr_bcd  in  8  hours, [7:4] tens digit, [3:0] ones digit
- min_bcd  in  8  minutes, same layout
- sec_bcd  in  8  seconds, same layout
- ms_bcd  in  8  ms, same layout
- busy  out  1  high while not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  last conversion rejected
- time_out  out  27  packed word: [26:22] hr, [21:16] min, [15:10] sec, [9:4] ms, [3:0] always 0

## Operation
- States: IDLE, CONV, CHECK, DONE.
- IDLE, start=1: latch all four BCD bytes into an input register, clear err, field index=0, go to CONV. Later input changes have no effect.
- CONV: one field per cycle, in order hr, min, sec, ms.
  - value = (tens<<3) + (tens<<1) + ones, computed 7 bits wide (max 99).
  - Store the result in a staging register.
  - Set a sticky bad flag if either nibble > 9 or value > that field's MAX.
  - After the ms field, go to CHECK.
- CHECK: if bad is clear, load time_out from staging. Each field is truncated to its width: hr 5 bits, others 6 bits. Bits [3:0] are 0. If bad is set, time_out holds its prior value and err is set. Go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- start is ignored in every state other than IDLE, including DONE. No queuing.
- err holds until the next accepted start or reset.
- time_out changes only on the CHECK→DONE edge, and only for a good conversion.

## Timing
- Reset (any state, including mid-conversion): state=IDLE, busy=0, done=0, err=0, time_out=0, staging/bad cleared.
- start sampled high in IDLE at edge k:
  - busy=1 from after edge k.
  - CONV occupies edges k+1..k+4.
  - CHECK is evaluated at edge k+5.
  - done=1 and the new time_out/err are visible after edge k+5.
  - done=0 and busy=0 after edge k+6.
- Latency: 6 cycles from start acceptance to the done pulse. Throughput: one conversion per 7 cycles (next start accepted at edge k+7 earliest, while IDLE).
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then start with hr=0x12, min=0x34, sec=0x56, ms=0x07 → done exactly 6 cycles after acceptance; time_out fields 12/34/56/7, [3:0]=0; err=0; busy high for 6 cycles.
- After a good load, start with min=0x1A → done pulse, err=1, time_out unchanged. A following good start clears err at acceptance.
- Range limits: hr=0x24 → err=1. hr=0x23, min=0x59, sec=0x59, ms=0x63 → err=0 and fields 23/59/59/63. ms=0x64 → err=1.
- Pulse start again at cycles 2 and 5 after acceptance, with different data → ignored; output reflects the first data set; only one done pulse.
- Assert reset during CONV (3 cycles after acceptance) → next cycle busy=0, done=0, err=0, time_out=0; no done pulse follows.
- Hold start high continuously with valid data → conversions accepted every 7 cycles, one done pulse per conversion, never two consecutive done cycles.

Source files
------------

// File: rtl/bcd_time_packer.sv
// Sequential BCD-to-binary time packer: validates four two-digit BCD fields, converts one per
// cycle and loads the packed 27-bit time word on a good conversion.
module bcd_time_packer #(
  parameter int unsigned HR_MAX  = 23,
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MS_MAX  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  hr_bcd,
  input  logic [7:0]  min_bcd,
  input  logic [7:0]  sec_bcd,
  input  logic [7:0]  ms_bcd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [26:0] time_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0][7:0]  in_q, in_d;       // index 0 = hr ... 3 = ms
  logic [1:0]       idx_q, idx_d;
  logic [4:0]       hr_q, hr_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       ms_q, ms_d;
  logic             bad_q, bad_d;
  logic             err_q, err_d;
  logic [26:0]      time_q, time_d;

  logic [7:0] cur;
  logic [3:0] tens, ones;
  logic [6:0] value;
  logic [6:0] field_max;
  logic       field_bad;

  assign cur   = in_q[idx_q];
  assign tens  = cur[7:4];
  assign ones  = cur[3:0];
  // tens*10 as shift-and-add
  assign value = ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};

  always_comb begin
    field_max = 7'(HR_MAX);
    unique case (idx_q)
      2'd0: field_max = 7'(HR_MAX);
      2'd1: field_max = 7'(MIN_MAX);
      2'd2: field_max = 7'(SEC_MAX);
      2'd3: field_max = 7'(MS_MAX);
    endcase
  end

  assign field_bad = (tens > 4'd9) || (ones > 4'd9) || (value > field_max);

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    idx_d   = idx_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    bad_d   = bad_q;
    err_d   = err_q;
    time_d  = time_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          in_d    = {ms_bcd, sec_bcd, min_bcd, hr_bcd};
          err_d   = 1'b0;
          bad_d   = 1'b0;
          idx_d   = 2'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        unique case (idx_q)
          2'd0: hr_d  = value[4:0];
          2'd1: min_d = value[5:0];
          2'd2: sec_d = value[5:0];
          2'd3: ms_d  = value[5:0];
        endcase
        if (field_bad) bad_d = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = CHECK;
      end
      CHECK: begin
        // A rejected conversion leaves the previously loaded word in place
        if (!bad_q) time_d = {hr_q, min_q, sec_q, ms_q, 4'b0000};
        else        err_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      in_q    <= '0;
      idx_q   <= 2'd0;
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      ms_q    <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      idx_q   <= idx_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      time_q  <= time_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign time_out = time_q;

endmodule
